clk_rst_seq: RTL and testbench
==============================

CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 SHALL have parameter N_DOM, default 4: number of reset/clock-enable domains (1..16).
REQ-002 SHALL have parameter DIV_W, default 4: per-domain divider ratio width.
REQ-003 SHALL have parameter STEP_DLY, default 4: cycles between successive domain reset releases (>=1).
REQ-004 SHALL have parameter SOFT_HOLD, default 8: cycles all resets are held low on a soft reset (>=1).
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 32: cycles to wait for PLL lock before fallback (>=1).
REQ-006 SHALL have port clk_i, input, 1: the single clock.
REQ-007 SHALL have port rstn_i, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port testmode_i, input, 1: scan/test bypass.
REQ-009 SHALL have port clk_sel_i, input, 1: 1 = PLL clock path in use, so lock is required.
REQ-010 SHALL have port pll_lock_i, input, 1: asynchronous PLL lock indication.
REQ-011 SHALL have port soft_reset_en_i, input, 1: enables soft_reset_req_i.
REQ-012 SHALL have port soft_reset_req_i, input, 1: soft reset request, level sampled each cycle.
REQ-013 SHALL have port div_ratio_i, input, N_DOM*DIV_W: divider ratio d_k for domain k, held in slice [k*DIV_W +: DIV_W].
REQ-014 SHALL have port rstn_o, output, N_DOM: per-domain active-low reset.
REQ-015 SHALL have port clk_en_o, output, N_DOM: per-domain clock-enable pulses.
REQ-016 SHALL have port pll_lock_o, output, 1: equals lock_s | ~clk_sel_i.
REQ-017 SHALL have port lock_timeout_o, output, 1: sticky flag meaning lock was not seen within LOCK_TIMEOUT.
REQ-018 SHALL have port busy_o, output, 1: high in every state except RUN.

Function
REQ-019 SHALL synchronise pll_lock_i through two flops; lock_s is the second flop's output; lock_s loses all meaning in reset and both flops clear.
REQ-020 SHALL implement FSM states WAIT_LOCK, RELEASE, RUN and SOFT_ASSERT.
REQ-021 WAIT_LOCK: if clk_sel_i=0 or lock_s=1, go to RELEASE on the next edge.
REQ-022 WAIT_LOCK: otherwise increment the timeout counter; when it reaches LOCK_TIMEOUT, set lock_timeout_o=1 and go to RELEASE.
REQ-023 RELEASE: rstn_o[k] SHALL rise STEP_DLY*(k+1) cycles after RELEASE entry; rstn_o[k] stays high once released; the FSM goes to RUN on the same edge that rstn_o[N_DOM-1] rises.
REQ-024 SOFT_ASSERT: all rstn_o are low for exactly SOFT_HOLD cycles, then the FSM goes to RELEASE without a lock check.
REQ-025 A soft trigger is soft_reset_req_i & soft_reset_en_i sampled in RELEASE or RUN; it SHALL drive all rstn_o low on the next edge and enter SOFT_ASSERT, restarting the hold count if already in SOFT_ASSERT.
REQ-026 Soft triggers SHALL be ignored in WAIT_LOCK.
REQ-027 Lock loss is clk_sel_i=1 and lock_s=0 in RELEASE, RUN or SOFT_ASSERT; it SHALL drive all rstn_o low on the next edge, clear the timeout counter and enter WAIT_LOCK.
REQ-028 When lock loss and a soft trigger occur together, lock loss SHALL take priority.
REQ-029 Domain k SHALL have a DIV_W-bit counter cnt_k, held at 0 while rstn_o[k]=0.
REQ-030 While rstn_o[k]=1, clk_en_o[k]=1 when cnt_k>=d_k, and cnt_k then wraps to 0; otherwise cnt_k increments.
REQ-031 d_k=0 SHALL give clk_en_o[k] constantly 1; d_k=2^DIV_W-1 SHALL give one pulse every 2^DIV_W cycles.
REQ-032 A change in d_k SHALL take effect immediately; if the new d_k is less than cnt_k, a pulse fires on the next cycle and the counter wraps.
REQ-033 clk_en_o[k] SHALL be 0 whenever rstn_o[k]=0 and testmode_i=0.
REQ-034 When testmode_i=1, every rstn_o SHALL equal rstn_i combinationally, every clk_en_o SHALL be 1, and the FSM SHALL keep running internally.
REQ-035 All outputs other than the testmode bypass and pll_lock_o SHALL be registered.

Reset
REQ-036 When rstn_i=0 at an edge, the block SHALL reset to state WAIT_LOCK, rstn_o=0, clk_en_o=0, all counters 0, lock_timeout_o=0 and busy_o=1.
REQ-037 rstn_i low mid-sequence, in any state, SHALL abort to the reset values on that edge.
REQ-038 lock_timeout_o SHALL clear only on rstn_i.

Verification
Bench parameters are N_DOM=4, STEP_DLY=4, SOFT_HOLD=8, LOCK_TIMEOUT=32, DIV_W=4. E0 is the first edge with rstn_i=1.
REQ-039 Stimulus: clk_sel_i=0, E0. Required: rstn_o[0..3] rise at E0+4, +8, +12, +16; busy_o falls at E0+16.
REQ-040 Stimulus: clk_sel_i=1, pll_lock_i rises at E0+10. Required: release at lock_s+1, rstn_o[0] rises 4 cycles later, and lock_timeout_o stays 0.
REQ-041 Stimulus: clk_sel_i=1, pll_lock_i held 0. Required: lock_timeout_o=1 at E0+32, the release sequence proceeds, and the flag stays set through a subsequent soft reset.
REQ-042 Stimulus: in RUN, soft_reset_en_i=1 with a one-cycle soft_reset_req_i. Required: all rstn_o low for 8 cycles, then re-released at 4-cycle steps; with soft_reset_en_i=0 the same request has no effect.
REQ-043 Stimulus: in RUN, d_0=0, d_1=3, d_2=15. Required: clk_en_o[0] constantly 1, clk_en_o[1] one pulse every 4 cycles, clk_en_o[2] one pulse every 16 cycles; changing d_2 to 2 while cnt_2=9 gives a pulse on the next cycle.
REQ-044 Stimulus: in RUN with clk_sel_i=1, drop pll_lock_i in the same cycle as a soft request. Required: all rstn_o low at lock_s fall+1, state WAIT_LOCK, and the lock loss wins; with testmode_i=1, rstn_o mirrors rstn_i.

Source files
------------

// File: rtl/clk_rst_seq.sv
// Reset/clock-enable sequencer: waits for PLL lock, releases N_DOM domain resets
// in timed steps, and produces a divided clock-enable pulse train per domain.
module clk_rst_seq #(
  parameter int N_DOM        = 4,
  parameter int DIV_W        = 4,
  parameter int STEP_DLY     = 4,
  parameter int SOFT_HOLD    = 8,
  parameter int LOCK_TIMEOUT = 32
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   testmode_i,
  input  logic                   clk_sel_i,
  input  logic                   pll_lock_i,
  input  logic                   soft_reset_en_i,
  input  logic                   soft_reset_req_i,
  input  logic [N_DOM*DIV_W-1:0] div_ratio_i,
  output logic [N_DOM-1:0]       rstn_o,
  output logic [N_DOM-1:0]       clk_en_o,
  output logic                   pll_lock_o,
  output logic                   lock_timeout_o,
  output logic                   busy_o
);

  localparam int REL_LEN = STEP_DLY * N_DOM;
  localparam int REL_W   = $clog2(REL_LEN + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam int HOLD_W  = $clog2(SOFT_HOLD + 1);
  localparam logic [REL_W-1:0]  REL_END   = REL_W'(REL_LEN);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(LOCK_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SOFT_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK   = 2'd0,
    RELEASE     = 2'd1,
    RUN         = 2'd2,
    SOFT_ASSERT = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [TO_W-1:0]   tcnt, tcnt_nxt;
  logic [REL_W-1:0]  rel_cnt, rel_nxt, rel_inc;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              timeout_q, timeout_nxt;
  logic              sync_p0, sync_p1, lock_s;
  logic              lock_loss, soft_trig;
  logic [N_DOM-1:0]  rstn_q, rstn_nxt;
  logic [N_DOM-1:0]  en_q, en_nxt;
  logic              busy_q, busy_nxt;
  logic [DIV_W-1:0]  cnt_q   [N_DOM];
  logic [DIV_W-1:0]  cnt_nxt [N_DOM];

  // Stage p0/p1: two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pll_lock_i;
      sync_p1 <= sync_p0;
    end
  end

  assign lock_s  = sync_p1;
  assign rel_inc = rel_cnt + 1'b1;

  // Once the timeout fallback has been taken the sequence runs without lock.
  assign lock_loss = clk_sel_i & ~lock_s & ~timeout_q;
  assign soft_trig = soft_reset_req_i & soft_reset_en_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= WAIT_LOCK;
      tcnt      <= '0;
      rel_cnt   <= '0;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      tcnt      <= tcnt_nxt;
      rel_cnt   <= rel_nxt;
      hold_cnt  <= hold_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tcnt_nxt    = tcnt;
    rel_nxt     = rel_cnt;
    hold_nxt    = hold_cnt;
    timeout_nxt = timeout_q;
    case (state)
      WAIT_LOCK: begin
        if (!clk_sel_i || lock_s) begin
          state_nxt = RELEASE;
          rel_nxt   = '0;
        end else if (tcnt >= TO_MAX) begin
          timeout_nxt = 1'b1;
          state_nxt   = RELEASE;
          rel_nxt     = '0;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      RELEASE: begin
        rel_nxt = rel_inc;
        if (rel_inc == REL_END) state_nxt = RUN;
      end
      RUN: state_nxt = RUN;
      SOFT_ASSERT: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = RELEASE;
          rel_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
    // Lock loss outranks a simultaneous soft request.
    if (state != WAIT_LOCK) begin
      if (lock_loss) begin
        state_nxt = WAIT_LOCK;
        tcnt_nxt  = '0;
      end else if (soft_trig) begin
        state_nxt = SOFT_ASSERT;
        hold_nxt  = '0;
      end
    end
  end

  always_comb begin
    rstn_nxt = '0;
    busy_nxt = (state_nxt != RUN);
    if (state_nxt == RELEASE || state_nxt == RUN) begin
      rstn_nxt = rstn_q;
      if (state == RELEASE) begin
        for (int k = 0; k < N_DOM; k++) begin
          if (rel_inc >= REL_W'(STEP_DLY * (k + 1))) rstn_nxt[k] = 1'b1;
        end
      end
    end
    for (int k = 0; k < N_DOM; k++) begin
      en_nxt[k]  = 1'b0;
      cnt_nxt[k] = '0;
      if (rstn_nxt[k]) begin
        if (cnt_q[k] >= div_ratio_i[k*DIV_W +: DIV_W]) en_nxt[k] = 1'b1;
        else cnt_nxt[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rstn_q <= '0;
      en_q   <= '0;
      busy_q <= 1'b1;
      for (int k = 0; k < N_DOM; k++) cnt_q[k] <= '0;
    end else begin
      rstn_q <= rstn_nxt;
      en_q   <= en_nxt;
      busy_q <= busy_nxt;
      for (int k = 0; k < N_DOM; k++) cnt_q[k] <= cnt_nxt[k];
    end
  end

  assign rstn_o         = testmode_i ? {N_DOM{rstn_i}} : rstn_q;
  assign clk_en_o       = testmode_i ? {N_DOM{1'b1}} : en_q;
  assign pll_lock_o     = lock_s | ~clk_sel_i;
  assign lock_timeout_o = timeout_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with N_DOM=4, STEP_DLY=4, SOFT_HOLD=8,
// LOCK_TIMEOUT=32, DIV_W=4; "m" below counts edges after E0.
module tb_clk_rst_seq;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        testmode_i;
  logic        clk_sel_i;
  logic        pll_lock_i;
  logic        soft_reset_en_i;
  logic        soft_reset_req_i;
  logic [15:0] div_ratio_i;
  logic [3:0]  rstn_o;
  logic [3:0]  clk_en_o;
  logic        pll_lock_o;
  logic        lock_timeout_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  clk_rst_seq #(
    .N_DOM(4), .DIV_W(4), .STEP_DLY(4), .SOFT_HOLD(8), .LOCK_TIMEOUT(32)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .testmode_i(testmode_i),
    .clk_sel_i(clk_sel_i),
    .pll_lock_i(pll_lock_i),
    .soft_reset_en_i(soft_reset_en_i),
    .soft_reset_req_i(soft_reset_req_i),
    .div_ratio_i(div_ratio_i),
    .rstn_o(rstn_o),
    .clk_en_o(clk_en_o),
    .pll_lock_o(pll_lock_o),
    .lock_timeout_o(lock_timeout_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    testmode_i = 1'b0; clk_sel_i = 1'b0; pll_lock_i = 1'b1;
    soft_reset_en_i = 1'b0; soft_reset_req_i = 1'b0;
    do_reset();
    checks++; if (rstn_o !== 4'h0) begin errors++; $display("FAIL reset_rstn got %b exp 0000", rstn_o); end
    checks++; if (clk_en_o !== 4'h0) begin errors++; $display("FAIL reset_clk_en got %b exp 0000", clk_en_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy_o); end
    checks++; if (lock_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", lock_timeout_o); end
    checks++; if (pll_lock_o !== 1'b1) begin errors++; $display("FAIL reset_pll_lock_sel0 got %b exp 1", pll_lock_o); end
    clk_sel_i = 1'b1; #1;
    checks++; if (pll_lock_o !== 1'b0) begin errors++; $display("FAIL reset_sync_cleared got %b exp 0", pll_lock_o); end
    clk_sel_i = 1'b0;
  endtask

  // Release without PLL, then divider patterns and a live ratio change on domain 2
  task automatic test_release_div();
    int dv [4] = '{0, 3, 15, 1};
    logic [3:0] exp_r, exp_e;
    int rk;
    pll_lock_i = 1'b0;
    div_ratio_i = {4'd1, 4'd15, 4'd3, 4'd0};
    do_reset();
    rstn_i = 1'b1;
    tick(1);
    for (int m = 0; m <= 60; m++) begin
      for (int k = 0; k < 4; k++) begin
        rk = 4 * (k + 1);
        exp_r[k] = (m >= rk);
        exp_e[k] = (m >= rk) && (((m - rk) % (dv[k] + 1)) == dv[k]);
      end
      if (m > 52) exp_e[2] = (m == 53) || ((m > 53) && (((m - 53) % 3) == 0));
      checks++; if (rstn_o !== exp_r) begin errors++; $display("FAIL release_rstn m=%0d got %b exp %b", m, rstn_o, exp_r); end
      checks++; if (busy_o !== (m < 16)) begin errors++; $display("FAIL release_busy m=%0d got %b exp %b", m, busy_o, (m < 16)); end
      checks++; if (clk_en_o !== exp_e) begin errors++; $display("FAIL div_clk_en m=%0d got %b exp %b", m, clk_en_o, exp_e); end
      if (m == 52) div_ratio_i[11:8] = 4'd2;
      tick(1);
    end
  endtask

  task automatic test_soft();
    logic [3:0] exp_r;
    soft_reset_en_i = 1'b0; soft_reset_req_i = 1'b1;
    tick(1);
    soft_reset_req_i = 1'b0;
    checks++; if (rstn_o !== 4'hF) begin errors++; $display("FAIL soft_disabled_rstn got %b exp 1111", rstn_o); end
    tick(2);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL soft_disabled_busy got %b exp 0", busy_o); end
    soft_reset_en_i = 1'b1; soft_reset_req_i = 1'b1;
    tick(1);
    soft_reset_req_i = 1'b0; soft_reset_en_i = 1'b0;
    checks++; if (rstn_o !== 4'h0) begin errors++; $display("FAIL soft_assert_rstn got %b exp 0000", rstn_o); end
    checks++; if (clk_en_o !== 4'h0) begin errors++; $display("FAIL soft_assert_clk_en got %b exp 0000", clk_en_o); end
    for (int j = 1; j <= 24; j++) begin
      tick(1);
      for (int k = 0; k < 4; k++) exp_r[k] = (j >= 12 + 4 * k);
      checks++; if (rstn_o !== exp_r) begin errors++; $display("FAIL soft_rerelease j=%0d got %b exp %b", j, rstn_o, exp_r); end
      checks++; if (busy_o !== (j < 24)) begin errors++; $display("FAIL soft_busy j=%0d got %b exp %b", j, busy_o, (j < 24)); end
    end
  endtask

  task automatic test_lock();
    logic [3:0] exp_r;
    clk_sel_i = 1'b1; pll_lock_i = 1'b0;
    do_reset();
    rstn_i = 1'b1;
    tick(1);
    for (int m = 0; m <= 30; m++) begin
      for (int k = 0; k < 4; k++) exp_r[k] = (m >= 16 + 4 * k);
      checks++; if (pll_lock_o !== (m >= 11)) begin errors++; $display("FAIL lock_sync m=%0d got %b exp %b", m, pll_lock_o, (m >= 11)); end
      checks++; if (rstn_o !== exp_r) begin errors++; $display("FAIL lock_release m=%0d got %b exp %b", m, rstn_o, exp_r); end
      checks++; if (lock_timeout_o !== 1'b0) begin errors++; $display("FAIL lock_no_timeout m=%0d got %b exp 0", m, lock_timeout_o); end
      if (m == 9) pll_lock_i = 1'b1;
      tick(1);
    end
  endtask

  // One-cycle lock dropout overlapping a held soft request
  task automatic test_lock_loss();
    logic [3:0] exp_r;
    pll_lock_i = 1'b0; soft_reset_en_i = 1'b1; soft_reset_req_i = 1'b1;
    for (int j = 0; j <= 20; j++) begin
      tick(1);
      for (int k = 0; k < 4; k++) exp_r[k] = (j >= 7 + 4 * k);
      checks++; if (rstn_o !== exp_r) begin errors++; $display("FAIL lockloss_rstn j=%0d got %b exp %b", j, rstn_o, exp_r); end
      checks++; if (pll_lock_o !== (j != 1)) begin errors++; $display("FAIL lockloss_sync j=%0d got %b exp %b", j, pll_lock_o, (j != 1)); end
      checks++; if (busy_o !== (j < 19)) begin errors++; $display("FAIL lockloss_busy j=%0d got %b exp %b", j, busy_o, (j < 19)); end
      if (j == 0) pll_lock_i = 1'b1;
      if (j == 2) begin soft_reset_req_i = 1'b0; soft_reset_en_i = 1'b0; end
    end
  endtask

  task automatic test_testmode();
    testmode_i = 1'b1; #1;
    checks++; if (rstn_o !== 4'hF) begin errors++; $display("FAIL tm_rstn_high got %b exp 1111", rstn_o); end
    checks++; if (clk_en_o !== 4'hF) begin errors++; $display("FAIL tm_clk_en got %b exp 1111", clk_en_o); end
    rstn_i = 1'b0; #1;
    checks++; if (rstn_o !== 4'h0) begin errors++; $display("FAIL tm_rstn_mirror_low got %b exp 0000", rstn_o); end
    checks++; if (clk_en_o !== 4'hF) begin errors++; $display("FAIL tm_clk_en_in_reset got %b exp 1111", clk_en_o); end
    tick(1);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midrun_reset_busy got %b exp 1", busy_o); end
    rstn_i = 1'b1; #1;
    checks++; if (rstn_o !== 4'hF) begin errors++; $display("FAIL tm_rstn_mirror_high got %b exp 1111", rstn_o); end
    testmode_i = 1'b0; #1;
    checks++; if (rstn_o !== 4'h0) begin errors++; $display("FAIL midrun_reset_rstn got %b exp 0000", rstn_o); end
    checks++; if (clk_en_o !== 4'h0) begin errors++; $display("FAIL midrun_reset_clk_en got %b exp 0000", clk_en_o); end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_r;
    clk_sel_i = 1'b1; pll_lock_i = 1'b0;
    do_reset();
    rstn_i = 1'b1;
    tick(1);
    for (int m = 0; m <= 48; m++) begin
      for (int k = 0; k < 4; k++) exp_r[k] = (m >= 36 + 4 * k);
      checks++; if (lock_timeout_o !== (m >= 32)) begin errors++; $display("FAIL timeout_flag m=%0d got %b exp %b", m, lock_timeout_o, (m >= 32)); end
      checks++; if (rstn_o !== exp_r) begin errors++; $display("FAIL timeout_release m=%0d got %b exp %b", m, rstn_o, exp_r); end
      checks++; if (busy_o !== (m < 48)) begin errors++; $display("FAIL timeout_busy m=%0d got %b exp %b", m, busy_o, (m < 48)); end
      if (m < 48) tick(1);
    end
    soft_reset_en_i = 1'b1; soft_reset_req_i = 1'b1;
    tick(1);
    soft_reset_req_i = 1'b0; soft_reset_en_i = 1'b0;
    checks++; if (rstn_o !== 4'h0) begin errors++; $display("FAIL timeout_soft_rstn got %b exp 0000", rstn_o); end
    for (int j = 1; j <= 24; j++) begin
      tick(1);
      for (int k = 0; k < 4; k++) exp_r[k] = (j >= 12 + 4 * k);
      checks++; if (rstn_o !== exp_r) begin errors++; $display("FAIL timeout_soft_rerelease j=%0d got %b exp %b", j, rstn_o, exp_r); end
      checks++; if (lock_timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky j=%0d got %b exp 1", j, lock_timeout_o); end
    end
    do_reset();
    checks++; if (lock_timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_cleared got %b exp 0", lock_timeout_o); end
    checks++; if (rstn_o !== 4'h0) begin errors++; $display("FAIL final_reset_rstn got %b exp 0000", rstn_o); end
  endtask

  initial begin
    rstn_i = 1'b0; testmode_i = 1'b0; clk_sel_i = 1'b0; pll_lock_i = 1'b0;
    soft_reset_en_i = 1'b0; soft_reset_req_i = 1'b0; div_ratio_i = '0;
    test_reset();
    test_release_div();
    test_soft();
    test_lock();
    test_lock_loss();
    test_testmode();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
